// File: rtl/svm_cfg_pkg.sv
// Shared types and register map for the SVM configuration loader.
package svm_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StWait,
    StFinWr,
    StAbort
  } cfg_state_e;

  localparam logic [15:0] CFG_DONE_ADDR = 16'd9;

  // SVM accelerator register map
  localparam logic [15:0] OP_MODE      = 16'd0;
  localparam logic [15:0] NUM_SV       = 16'd1;
  localparam logic [15:0] NUM_FEAT     = 16'd2;
  localparam logic [15:0] KERNEL_SEL   = 16'd3;
  localparam logic [15:0] GAMMA        = 16'd4;
  localparam logic [15:0] COEF0        = 16'd5;
  localparam logic [15:0] POLY_DEGREE  = 16'd6;
  localparam logic [15:0] BIAS         = 16'd7;
  localparam logic [15:0] SV_BASE      = 16'd8;
  localparam logic [15:0] CFG_DONE     = 16'd9;
  localparam logic [15:0] ALPHA_BASE   = 16'd10;
  localparam logic [15:0] FEAT_SCALE   = 16'd11;
  localparam logic [15:0] FEAT_OFFSET  = 16'd12;
  localparam logic [15:0] IRQ_EN       = 16'd13;
  localparam logic [15:0] STATUS       = 16'd14;
  localparam logic [15:0] SCATTER_BASE = 16'd15;

endpackage

// File: rtl/svm_cfg_loader_if.sv
// Register bus between the config loader (master) and the register responder (slave).
interface svm_cfg_loader_if;
  logic        cfg_req_vld;
  logic        cfg_data_rb_w;
  logic [15:0] cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_data_rd_vld;
  logic [31:0] cfg_rd_data;

  modport master (
    output cfg_req_vld, cfg_data_rb_w, cfg_addr, cfg_data,
    input  cfg_data_rd_vld, cfg_rd_data
  );

  modport slave (
    input  cfg_req_vld, cfg_data_rb_w, cfg_addr, cfg_data,
    output cfg_data_rd_vld, cfg_rd_data
  );
endinterface

// File: rtl/svm_cfg_timeout_cnt.sv
// Read-back timeout counter: clear, count enabled cycles, flag the LIMIT-th one.
module svm_cfg_timeout_cnt #(
  parameter int unsigned LIMIT = 15,
  localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The current enabled cycle counts, so expiry marks the LIMIT-th waiting cycle.
  assign expired = en && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/svm_cfg_loader.sv
// Streams a config table onto the register bus, optionally verifying each write by read-back.
module svm_cfg_loader
  import svm_cfg_pkg::*;
#(
  parameter int unsigned N_ENTRIES   = 16,
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter logic [15:0] DONE_ADDR   = CFG_DONE_ADDR,
  localparam int unsigned IDX_W      = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 verify_en,
  output logic [IDX_W-1:0]     tbl_idx,
  input  logic [15:0]          tbl_addr,
  input  logic [31:0]          tbl_data,
  svm_cfg_loader_if.master     cfg,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IDX_W-1:0]     err_idx
);

  cfg_state_e       state_q;
  logic [IDX_W-1:0] idx_q;
  logic             verify_q;
  logic [15:0]      addr_q;
  logic [31:0]      exp_q;
  logic             done_q;
  logic             err_q;
  logic [IDX_W-1:0] err_idx_q;
  logic             last_entry;
  logic             tmr_expired;

  assign last_entry = (idx_q == IDX_W'(N_ENTRIES - 1));

  svm_cfg_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == StRd),
    .en      (state_q == StWait),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      verify_q  <= 1'b0;
      addr_q    <= '0;
      exp_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StWr;
            idx_q     <= '0;
            verify_q  <= verify_en;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
          end
        end
        StWr: begin
          addr_q <= tbl_addr;
          exp_q  <= tbl_data;
          if (verify_q) begin
            state_q <= StRd;
          end else if (last_entry) begin
            state_q <= StFinWr;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StWr;
          end
        end
        StRd: state_q <= StWait;
        StWait: begin
          // Read data arriving in the expiry cycle wins over the timeout.
          if (cfg.cfg_data_rd_vld) begin
            if (cfg.cfg_rd_data != exp_q) begin
              state_q <= StAbort;
            end else if (last_entry) begin
              state_q <= StFinWr;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= StWr;
            end
          end else if (tmr_expired) begin
            state_q <= StAbort;
          end
        end
        StFinWr: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        StAbort: begin
          err_q     <= 1'b1;
          err_idx_q <= idx_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg.cfg_req_vld   = (state_q == StWr) || (state_q == StRd) || (state_q == StFinWr);
  assign cfg.cfg_data_rb_w = (state_q == StWr) || (state_q == StFinWr);

  always_comb begin
    cfg.cfg_addr = '0;
    cfg.cfg_data = '0;
    case (state_q)
      StWr: begin
        cfg.cfg_addr = tbl_addr;
        cfg.cfg_data = tbl_data;
      end
      StRd:    cfg.cfg_addr = addr_q;
      StFinWr: begin
        cfg.cfg_addr = DONE_ADDR;
        cfg.cfg_data = 32'h1;
      end
      default: ;
    endcase
  end

  assign tbl_idx = idx_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign err     = err_q;
  assign err_idx = err_idx_q;

endmodule

// File: tb/tb_svm_cfg_loader.sv
// Self-checking bench for svm_cfg_loader: scoreboarded bus transactions, table-driven runs.
module tb_svm_cfg_loader;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        verify_en;
  logic [3:0]  tbl_idx;
  logic [15:0] tbl_addr;
  logic [31:0] tbl_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  err_idx;

  svm_cfg_loader_if bus ();

  svm_cfg_loader #(
    .N_ENTRIES   (16),
    .TIMEOUT_CYC (15),
    .DONE_ADDR   (16'd9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .verify_en (verify_en),
    .tbl_idx   (tbl_idx),
    .tbl_addr  (tbl_addr),
    .tbl_data  (tbl_data),
    .cfg       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_idx   (err_idx)
  );

  always #5 clk = ~clk;

  // External config table: entry i -> address i, value i+100
  assign tbl_addr = 16'(tbl_idx);
  assign tbl_data = 32'(tbl_idx) + 32'd100;

  typedef struct packed {
    logic        rb_w;
    logic [15:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    bit verify;
    bit noise;
    int mid_start;
    int f_idx;
    bit f_bad;
    int f_dly;
    bit exp_done;
    bit exp_err;
    int exp_err_idx;
    int exp_cycles;
    int exp_nreq;
  } vec_t;

  vec_t        vecs[9];
  txn_t        exp_txn[$];
  int          checks = 0;
  int          errors = 0;
  int          n_req;
  int          rsp_cnt = -1;
  logic [31:0] rsp_data;
  bit          noise = 0;
  int          f_idx = -1;
  bit          f_bad = 0;
  int          f_dly = 2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: monitor the bus against the scoreboard, then drive the responder.
  task automatic tick();
    txn_t obs;
    txn_t e;
    int   a;
    @(posedge clk);
    #1;
    obs = {bus.cfg_data_rb_w, bus.cfg_addr, bus.cfg_data};
    if (bus.cfg_req_vld === 1'b1) begin
      n_req++;
      if (exp_txn.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req actual=%0h required=none", obs);
      end else begin
        e = exp_txn.pop_front();
        chk("bus_txn", 64'(obs), 64'(e));
      end
    end else begin
      chk("idle_bus_zero", 64'({bus.cfg_addr, bus.cfg_data}), 64'(0));
    end

    bus.cfg_data_rd_vld = 1'b0;
    bus.cfg_rd_data     = '0;
    if (noise) begin
      bus.cfg_data_rd_vld = 1'b1;
      bus.cfg_rd_data     = $urandom;
    end else if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        bus.cfg_data_rd_vld = 1'b1;
        bus.cfg_rd_data     = rsp_data;
        rsp_cnt             = -1;
      end
    end
    if (bus.cfg_req_vld === 1'b1 && bus.cfg_data_rb_w === 1'b0 && !noise) begin
      a = int'(bus.cfg_addr);
      if (a == f_idx && !f_bad) begin
        if (f_dly > 0) rsp_cnt = f_dly;
        rsp_data = 32'(a) + 32'd100;
      end else begin
        rsp_cnt  = 2;
        rsp_data = (a == f_idx) ? 32'hDEAD : 32'(a) + 32'd100;
      end
    end
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int last;
    int cyc;
    exp_txn.delete();
    last = v.exp_err ? v.exp_err_idx : N - 1;
    for (int i = 0; i <= last; i++) begin
      exp_txn.push_back({1'b1, 16'(i), 32'(i) + 32'd100});
      if (v.verify) exp_txn.push_back({1'b0, 16'(i), 32'd0});
    end
    if (!v.exp_err) exp_txn.push_back({1'b1, 16'd9, 32'd1});
    noise     = v.noise;
    f_idx     = v.f_idx;
    f_bad     = v.f_bad;
    f_dly     = v.f_dly;
    n_req     = 0;
    verify_en = v.verify;
    start     = 1'b1;
    for (cyc = 1; cyc <= 300; cyc++) begin
      tick();
      start = (cyc == v.mid_start);
      if (cyc == 1) chk($sformatf("v%0d_start_clears", vi), 64'({busy, done, err}), 64'(3'b100));
      if (done === 1'b1 || err === 1'b1) break;
    end
    start     = 1'b0;
    noise     = 0;
    verify_en = 1'b0;
    chk($sformatf("v%0d_end_cycle", vi), 64'(cyc), 64'(v.exp_cycles));
    chk($sformatf("v%0d_done", vi), 64'(done), 64'(v.exp_done));
    chk($sformatf("v%0d_err", vi), 64'(err), 64'(v.exp_err));
    if (v.exp_err) chk($sformatf("v%0d_err_idx", vi), 64'(err_idx), 64'(v.exp_err_idx));
    chk($sformatf("v%0d_busy", vi), 64'(busy), 64'(0));
    chk($sformatf("v%0d_nreq", vi), 64'(n_req), 64'(v.exp_nreq));
    chk($sformatf("v%0d_sb_empty", vi), 64'(exp_txn.size()), 64'(0));
    tick();
    tick();
  endtask

  initial begin
    // verify noise mid f_idx bad dly done err eidx cycles nreq
    vecs[0] = '{0, 0, 0, -1, 0, 2, 1, 0, 0, 18, 17};
    vecs[1] = '{0, 1, 5, -1, 0, 2, 1, 0, 0, 18, 17};
    vecs[2] = '{1, 0, 0, -1, 0, 2, 1, 0, 0, 66, 33};
    vecs[3] = '{1, 0, 0, 5, 1, 2, 0, 1, 5, 26, 12};
    vecs[4] = '{1, 0, 0, 3, 0, 0, 0, 1, 3, 31, 8};
    vecs[5] = '{1, 0, 0, 3, 0, 15, 1, 0, 0, 79, 33};
    vecs[6] = '{1, 0, 0, 15, 1, 2, 0, 1, 15, 66, 32};
    vecs[7] = '{1, 0, 0, 0, 1, 2, 0, 1, 0, 6, 2};
    vecs[8] = '{1, 0, 0, 3, 0, 16, 0, 1, 3, 31, 8};

    rst_n               = 1'b0;
    start               = 1'b0;
    verify_en           = 1'b0;
    bus.cfg_data_rd_vld = 1'b0;
    bus.cfg_rd_data     = '0;
    tick();
    start = 1'b1;
    tick();
    chk("rst_outputs", 64'({bus.cfg_req_vld, busy, done, err, err_idx, tbl_idx}), 64'(0));
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rst_idle_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset while entry 7 is being written
    exp_txn.delete();
    for (int i = 0; i <= 7; i++) exp_txn.push_back({1'b1, 16'(i), 32'(i) + 32'd100});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_rst_at_idx7", 64'(tbl_idx), 64'(7));
    rst_n = 1'b0;
    tick();
    chk("mid_rst_req", 64'(bus.cfg_req_vld), 64'(0));
    chk("mid_rst_status", 64'({busy, done, err, tbl_idx}), 64'(0));
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_status", 64'({busy, done, err}), 64'(0));
    chk("post_rst_sb_empty", 64'(exp_txn.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
